// File: rtl/interleave_counter_bank_pkg.sv
// Shared types and helpers for the interleave counter bank.
// Optional status logic is enabled with `define INTERLEAVE_CTR_BANK_STATUS_EN.
package interleave_pkg;

    // Per-channel operation after priority resolution.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } ctr_op_e;

    // 64-bit constants. Users slice them to the counter width, so widths up to 64 are supported.
    localparam logic [63:0] CTR_ZERO_64 = 64'd0;
    localparam logic [63:0] CTR_ONE_64  = 64'd1;
    localparam logic [63:0] CTR_MAX_64  = {64{1'b1}};

    // Load wins. Increment and decrement cancel each other out.
    function automatic ctr_op_e ctr_decode_op(input logic load, input logic incr, input logic decr);
        if (load) begin
            return LOAD;
        end else if (incr && !decr) begin
            return INC;
        end else if (decr && !incr) begin
            return DEC;
        end
        return HOLD;
    endfunction

endpackage

// File: rtl/interleave_counter_bank_chan.sv
// One channel of the interleave counter bank.
// The channel contains the counter register, the next-value logic, and the registered
// zero, threshold and wrap flags. The flags are derived from the next count, so they
// always line up with the count that is presented in the same cycle.
// Build option: `define INTERLEAVE_CTR_BANK_STATUS_EN adds status_clr and wrap_err.
module interleave_counter_bank_chan
    import interleave_pkg::*;
#(
    parameter int                 C_WIDTH    = 4,
    parameter logic [C_WIDTH-1:0] C_INIT     = '0,
    parameter int                 C_SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clken,
    input  logic               load,
    input  logic               incr,
    input  logic               decr,
    input  logic [C_WIDTH-1:0] load_value,
    input  logic [C_WIDTH-1:0] thresh,
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
    input  logic               status_clr,
    output logic               wrap_err,
`endif
    output logic [C_WIDTH-1:0] count,
    output logic               is_zero,
    output logic               at_thresh,
    output logic               zero_next
);

    localparam logic [C_WIDTH-1:0] ZERO_V = CTR_ZERO_64[C_WIDTH-1:0];
    localparam logic [C_WIDTH-1:0] ONE_V  = CTR_ONE_64[C_WIDTH-1:0];
    localparam logic [C_WIDTH-1:0] MAX_V  = CTR_MAX_64[C_WIDTH-1:0];

    logic [C_WIDTH-1:0] count_q, count_d;
    logic               is_zero_q, at_thresh_q;
    logic               wrap_hit;
    ctr_op_e            op;

    assign op = ctr_decode_op(load, incr, decr);

    // Next count. A range-limit crossing is flagged whether the counter wraps or clamps.
    always_comb begin
        count_d  = count_q;
        wrap_hit = 1'b0;
        if (clken) begin
            case (op)
                LOAD: count_d = load_value;
                INC: begin
                    wrap_hit = (count_q == MAX_V);
                    if (!(wrap_hit && (C_SATURATE != 0))) begin
                        count_d = count_q + ONE_V;
                    end
                end
                DEC: begin
                    wrap_hit = (count_q == ZERO_V);
                    if (!(wrap_hit && (C_SATURATE != 0))) begin
                        count_d = count_q - ONE_V;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    // Counter register and the flags that track it. While clken is low, everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= C_INIT;
            is_zero_q   <= (C_INIT == ZERO_V);
            at_thresh_q <= 1'b0;
        end else if (clken) begin
            count_q     <= count_d;
            is_zero_q   <= (count_d == ZERO_V);
            at_thresh_q <= (count_d >= thresh);
        end
    end

`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
    logic wrap_err_q;

    // Sticky wrap flag. A crossing in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_err_q <= 1'b0;
        end else if (clken) begin
            if (wrap_hit) begin
                wrap_err_q <= 1'b1;
            end else if (status_clr) begin
                wrap_err_q <= 1'b0;
            end
        end
    end

    assign wrap_err = wrap_err_q;
`endif

    assign count     = count_q;
    assign is_zero   = is_zero_q;
    assign at_thresh = at_thresh_q;
    // When clken is low, count_d equals count_q, so this reflects the held flag.
    assign zero_next = (count_d == ZERO_V);

endmodule

// File: rtl/interleave_counter_bank.sv
// Bank of C_CHANNELS independent up/down counters that share one clock enable.
// The bank adds a registered summary of zero counters: any_zero and the lowest zero index.
// Build option: `define INTERLEAVE_CTR_BANK_STATUS_EN adds status_clr and a sticky wrap_err vector.
module interleave_counter_bank
    import interleave_pkg::*;
#(
    parameter int                 C_WIDTH    = 4,
    parameter int                 C_CHANNELS = 4,
    parameter logic [C_WIDTH-1:0] C_INIT     = '0,
    parameter int                 C_SATURATE = 0,
    localparam int                IDX_W      = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clken,
    input  logic [C_CHANNELS-1:0]         load,
    input  logic [C_CHANNELS-1:0]         incr,
    input  logic [C_CHANNELS-1:0]         decr,
    input  logic [C_CHANNELS*C_WIDTH-1:0] load_value,
    input  logic [C_CHANNELS*C_WIDTH-1:0] thresh,
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
    input  logic                          status_clr,
    output logic [C_CHANNELS-1:0]         wrap_err,
`endif
    output logic [C_CHANNELS*C_WIDTH-1:0] count,
    output logic [C_CHANNELS-1:0]         is_zero,
    output logic [C_CHANNELS-1:0]         at_thresh,
    output logic                          any_zero,
    output logic [IDX_W-1:0]              first_zero_idx
);

    logic [C_CHANNELS-1:0] zero_next;
    logic                  any_zero_q;
    logic [IDX_W-1:0]      first_zero_idx_q, first_zero_idx_d;

    generate
        for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_chan
            interleave_counter_bank_chan #(
                .C_WIDTH    (C_WIDTH),
                .C_INIT     (C_INIT),
                .C_SATURATE (C_SATURATE)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .clken      (clken),
                .load       (load[gi]),
                .incr       (incr[gi]),
                .decr       (decr[gi]),
                .load_value (load_value[gi*C_WIDTH +: C_WIDTH]),
                .thresh     (thresh[gi*C_WIDTH +: C_WIDTH]),
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
                .status_clr (status_clr),
                .wrap_err   (wrap_err[gi]),
`endif
                .count      (count[gi*C_WIDTH +: C_WIDTH]),
                .is_zero    (is_zero[gi]),
                .at_thresh  (at_thresh[gi]),
                .zero_next  (zero_next[gi])
            );
        end
    endgenerate

    // Priority encoder over the next-cycle zero flags. The downward scan makes the lowest index win.
    always_comb begin
        first_zero_idx_d = '0;
        for (int i = C_CHANNELS - 1; i >= 0; i--) begin
            if (zero_next[i]) begin
                first_zero_idx_d = i[IDX_W-1:0];
            end
        end
    end

    // Registered summary. zero_next already holds when clken is low, so no extra gating is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_zero_q       <= (C_INIT == '0);
            first_zero_idx_q <= '0;
        end else begin
            any_zero_q       <= |zero_next;
            first_zero_idx_q <= first_zero_idx_d;
        end
    end

    assign any_zero       = any_zero_q;
    assign first_zero_idx = first_zero_idx_q;

endmodule

// File: tb/tb_interleave_counter_bank.sv
// Directed test of interleave_counter_bank with 4 channels of 4 bits each.
// Two instances share their inputs: dut_w wraps at the range limits and dut_s saturates.
// When INTERLEAVE_CTR_BANK_STATUS_EN is defined, the sticky wrap_err vector is checked as well.
module tb_interleave_counter_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clken;
    logic [3:0]  load, incr, decr;
    logic [15:0] load_value, thresh;
    logic [15:0] cnt_w, cnt_s;
    logic [3:0]  isz_w, isz_s, ath_w, ath_s;
    logic        anz_w, anz_s;
    logic [1:0]  idx_w, idx_s;
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
    logic        status_clr;
    logic [3:0]  werr_w, werr_s;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    interleave_counter_bank #(.C_WIDTH(4), .C_CHANNELS(4), .C_INIT(4'd0), .C_SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .load_value(load_value), .thresh(thresh),
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        .status_clr(status_clr), .wrap_err(werr_w),
`endif
        .count(cnt_w), .is_zero(isz_w), .at_thresh(ath_w), .any_zero(anz_w), .first_zero_idx(idx_w)
    );

    interleave_counter_bank #(.C_WIDTH(4), .C_CHANNELS(4), .C_INIT(4'd0), .C_SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .load_value(load_value), .thresh(thresh),
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        .status_clr(status_clr), .wrap_err(werr_s),
`endif
        .count(cnt_s), .is_zero(isz_s), .at_thresh(ath_s), .any_zero(anz_s), .first_zero_idx(idx_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 4'b0; incr = 4'b0; decr = 4'b0;
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        status_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clken = 1'b0; load_value = 16'h0; thresh = 16'hFFFF;
        idle_inputs();
        #12;
        checks++; if (cnt_w !== 16'h0000) $display("FAIL reset_count got=%h exp=0000", cnt_w); else passes++;
        checks++; if (isz_w !== 4'b1111) $display("FAIL reset_is_zero got=%b exp=1111", isz_w); else passes++;
        checks++; if (ath_w !== 4'b0000) $display("FAIL reset_at_thresh got=%b exp=0000", ath_w); else passes++;
        checks++; if (anz_w !== 1'b1 || idx_w !== 2'd0) $display("FAIL reset_summary got any=%b idx=%0d exp any=1 idx=0", anz_w, idx_w); else passes++;
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        checks++; if (werr_w !== 4'b0) $display("FAIL reset_wrap_err got=%b exp=0000", werr_w); else passes++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        clken = 1'b1;
        $display("txn reset: count=%h is_zero=%b any=%b idx=%0d", cnt_w, isz_w, anz_w, idx_w);
    endtask

    task automatic test_load();
        load = 4'b0100; load_value = 16'h0500;
        tick();
        idle_inputs();
        checks++; if (cnt_w[11:8] !== 4'd5) $display("FAIL load_count2 got=%0d exp=5", cnt_w[11:8]); else passes++;
        checks++; if (isz_w !== 4'b1011) $display("FAIL load_is_zero got=%b exp=1011", isz_w); else passes++;
        checks++; if (anz_w !== 1'b1 || idx_w !== 2'd0) $display("FAIL load_summary got any=%b idx=%0d exp any=1 idx=0", anz_w, idx_w); else passes++;
        $display("txn load ch2=5: count=%h is_zero=%b", cnt_w, isz_w);
    endtask

    task automatic test_wrap();
        load = 4'b0001; load_value = 16'h000F;
        tick();
        idle_inputs();
        incr = 4'b0001;
        tick();
        idle_inputs();
        checks++; if (cnt_w[3:0] !== 4'd0) $display("FAIL wrap_inc_count got=%0d exp=0", cnt_w[3:0]); else passes++;
        checks++; if (isz_w[0] !== 1'b1) $display("FAIL wrap_inc_is_zero got=%b exp=1", isz_w[0]); else passes++;
        checks++; if (cnt_s[3:0] !== 4'd15) $display("FAIL sat_inc_count got=%0d exp=15", cnt_s[3:0]); else passes++;
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        checks++; if (werr_w[0] !== 1'b1 || werr_s[0] !== 1'b1) $display("FAIL wrap_err0 got w=%b s=%b exp 1/1", werr_w[0], werr_s[0]); else passes++;
`endif
        decr = 4'b0001;
        tick();
        idle_inputs();
        checks++; if (cnt_w[3:0] !== 4'd15) $display("FAIL wrap_dec_count got=%0d exp=15", cnt_w[3:0]); else passes++;
        checks++; if (cnt_s[3:0] !== 4'd14) $display("FAIL sat_dec_count got=%0d exp=14", cnt_s[3:0]); else passes++;
        $display("txn wrap ch0: w=%0d s=%0d", cnt_w[3:0], cnt_s[3:0]);
    endtask

    task automatic test_saturate();
        logic [3:0] exp_w;
        for (int k = 0; k < 3; k++) begin
            decr = 4'b0010;
            tick();
            idle_inputs();
            exp_w = 4'd15 - k[3:0];
            checks++; if (cnt_s[7:4] !== 4'd0) $display("FAIL sat_dec_hold%0d got=%0d exp=0", k, cnt_s[7:4]); else passes++;
            checks++; if (cnt_w[7:4] !== exp_w) $display("FAIL wrap_dec_ch1_%0d got=%0d exp=%0d", k, cnt_w[7:4], exp_w); else passes++;
            $display("txn decr ch1 #%0d: w=%0d s=%0d", k, cnt_w[7:4], cnt_s[7:4]);
        end
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        checks++; if (werr_s[1] !== 1'b1) $display("FAIL sat_wrap_err1 got=%b exp=1", werr_s[1]); else passes++;
`endif
        load = 4'b0010; load_value = 16'h00F0;
        tick();
        idle_inputs();
        incr = 4'b0010;
        tick();
        idle_inputs();
        checks++; if (cnt_s[7:4] !== 4'd15) $display("FAIL sat_inc_hold got=%0d exp=15", cnt_s[7:4]); else passes++;
        checks++; if (cnt_w[7:4] !== 4'd0) $display("FAIL wrap_inc_ch1 got=%0d exp=0", cnt_w[7:4]); else passes++;
        $display("txn incr ch1 at max: w=%0d s=%0d", cnt_w[7:4], cnt_s[7:4]);
    endtask

`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
    task automatic test_status_clr();
        // dut_w ch1 is 0 and wraps again on this decrement, so the set wins over the clear.
        // dut_s ch1 is 15, which is an ordinary decrement.
        status_clr = 1'b1; decr = 4'b0010;
        tick();
        idle_inputs();
        checks++; if (werr_w !== 4'b0010) $display("FAIL clr_vs_set_w got=%b exp=0010", werr_w); else passes++;
        checks++; if (werr_s !== 4'b0000) $display("FAIL clr_s got=%b exp=0000", werr_s); else passes++;
        $display("txn status_clr: w=%b s=%b", werr_w, werr_s);
    endtask
`endif

    task automatic test_priority();
        load = 4'b1000; incr = 4'b1000; load_value = 16'h7000;
        tick();
        idle_inputs();
        checks++; if (cnt_w[15:12] !== 4'd7) $display("FAIL load_over_incr got=%0d exp=7", cnt_w[15:12]); else passes++;
        incr = 4'b1000; decr = 4'b1000;
        tick();
        idle_inputs();
        checks++; if (cnt_w[15:12] !== 4'd7) $display("FAIL incr_decr_hold got=%0d exp=7", cnt_w[15:12]); else passes++;
        clken = 1'b0; incr = 4'b1000;
        tick();
        idle_inputs();
        clken = 1'b1;
        checks++; if (cnt_w[15:12] !== 4'd7 || cnt_s[15:12] !== 4'd7) $display("FAIL clken_hold got w=%0d s=%0d exp=7", cnt_w[15:12], cnt_s[15:12]); else passes++;
        $display("txn priority ch3: count3=%0d", cnt_w[15:12]);
    endtask

    task automatic test_thresh();
        thresh = 16'h8FFF;
        tick();
        checks++; if (ath_w[3] !== 1'b0) $display("FAIL thresh_below got=%b exp=0", ath_w[3]); else passes++;
        incr = 4'b1000;
        tick();
        idle_inputs();
        checks++; if (cnt_w[15:12] !== 4'd8 || ath_w[3] !== 1'b1) $display("FAIL thresh_reach got cnt=%0d at=%b exp cnt=8 at=1", cnt_w[15:12], ath_w[3]); else passes++;
        checks++; if (ath_w[2] !== 1'b0) $display("FAIL thresh_ch2_before got=%b exp=0", ath_w[2]); else passes++;
        // Lowering thresh3 keeps the flag set. Lowering thresh2 to equal its count raises that flag.
        thresh = 16'h35FF;
        tick();
        checks++; if (ath_w[3] !== 1'b1) $display("FAIL thresh_lowered got=%b exp=1", ath_w[3]); else passes++;
        checks++; if (ath_w[2] !== 1'b1) $display("FAIL thresh_equal got=%b exp=1", ath_w[2]); else passes++;
        $display("txn thresh: at_thresh=%b", ath_w);
    endtask

    task automatic test_async_reset_and_summary();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (cnt_w !== 16'h0000 || cnt_s !== 16'h0000) $display("FAIL async_rst_count got w=%h s=%h exp=0000", cnt_w, cnt_s); else passes++;
        checks++; if (isz_w !== 4'b1111 || ath_w !== 4'b0000) $display("FAIL async_rst_flags got z=%b t=%b exp z=1111 t=0000", isz_w, ath_w); else passes++;
        checks++; if (anz_w !== 1'b1 || idx_w !== 2'd0) $display("FAIL async_rst_summary got any=%b idx=%0d exp any=1 idx=0", anz_w, idx_w); else passes++;
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        checks++; if (werr_w !== 4'b0) $display("FAIL async_rst_wrap_err got=%b exp=0000", werr_w); else passes++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        load = 4'b1111; load_value = 16'h3124;
        tick();
        idle_inputs();
        checks++; if (cnt_w !== 16'h3124) $display("FAIL load_all got=%h exp=3124", cnt_w); else passes++;
        checks++; if (anz_w !== 1'b0 || idx_w !== 2'd0) $display("FAIL none_zero got any=%b idx=%0d exp any=0 idx=0", anz_w, idx_w); else passes++;
        decr = 4'b0100;
        tick();
        idle_inputs();
        checks++; if (anz_w !== 1'b1 || idx_w !== 2'd2 || isz_w !== 4'b0100) $display("FAIL zero_ch2 got any=%b idx=%0d z=%b exp any=1 idx=2 z=0100", anz_w, idx_w, isz_w); else passes++;
        decr = 4'b0010;
        tick();
        tick();
        idle_inputs();
        checks++; if (cnt_w[7:4] !== 4'd0 || idx_w !== 2'd1) $display("FAIL lowest_zero got cnt1=%0d idx=%0d exp cnt1=0 idx=1", cnt_w[7:4], idx_w); else passes++;
        checks++; if (anz_s !== 1'b1 || idx_s !== 2'd1) $display("FAIL lowest_zero_s got any=%b idx=%0d exp any=1 idx=1", anz_s, idx_s); else passes++;
        $display("txn summary: count=%h any=%b idx=%0d", cnt_w, anz_w, idx_w);
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_saturate();
`ifdef INTERLEAVE_CTR_BANK_STATUS_EN
        test_status_clr();
`endif
        test_priority();
        test_thresh();
        test_async_reset_and_summary();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
